// File: rtl/ram_stream_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_stream_loader_pkg
// Brief   : Shared memory map and loader state encoding for the frame path
//           (data RAM, CPU and stream loader all import this package).
// Revision: 1.0 - initial release
// ============================================================================
package ram_stream_loader_pkg;

    localparam int WIDTH_DEFAULT     = 32;
    localparam int NWORDS_DEFAULT    = 1200;
    localparam int BASE_DEFAULT      = 206800;
    localparam int CTRL_ADDR_DEFAULT = 411698;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        FLAG  = 3'd3,
        POLL  = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_stream_loader_if
// Brief   : Stream input (valid/ready/data) plus one RAM port
//           (address/wdata/enw/rdata) seen by the frame loader.
// Revision: 1.0 - initial release
// ============================================================================
interface ram_stream_loader_if
    import ram_stream_loader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] wdata;
    logic             enw;
    logic [WIDTH-1:0] rdata;

    // Loader side: consumes the stream, drives the RAM port.
    modport master (
        input  in_valid,
        output in_ready,
        input  in_data,
        output address,
        output wdata,
        output enw,
        input  rdata
    );

    // Environment side: stream source and RAM.
    modport slave (
        output in_valid,
        input  in_ready,
        output in_data,
        input  address,
        input  wdata,
        input  enw,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/ram_stream_loader.sv
`default_nettype none
// ============================================================================
// Module  : ram_stream_loader
// Brief   : Writes one NWORDS-word frame from a valid/ready stream into the
//           data RAM at BASE.., raises the frame-ready control word, then
//           polls until the CPU clears it before accepting another frame.
// Revision: 1.0 - initial release
// ============================================================================
module ram_stream_loader
    import ram_stream_loader_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int NWORDS    = NWORDS_DEFAULT,
    parameter int BASE      = BASE_DEFAULT,
    parameter int CTRL_ADDR = CTRL_ADDR_DEFAULT
) (
    input  wire                 clk,
    input  wire                 reset,
    input  wire                 start,
    ram_stream_loader_if.master bus,
    output logic                busy,
    output logic                frame_done,
    output logic [15:0]         frames
);

    localparam int               c_cnt_w = $clog2(NWORDS + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(NWORDS - 1);
    localparam logic [WIDTH-1:0] c_base  = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] c_ctrl  = WIDTH'(CTRL_ADDR);

    loader_state_t        r_state;
    loader_state_t        w_next;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_hs;
    logic                 w_ack;

    assign bus.in_ready = (r_state == LOAD);
    assign busy         = (r_state != IDLE);
    assign w_hs         = (r_state == LOAD) && bus.in_valid;

    // The first POLL cycle still carries the flag write on the port, so the
    // combinational read then returns the pre-write value; only cycles with
    // the write enable low count as a genuine CPU acknowledge.
    assign w_ack = (r_state == POLL) && !bus.enw && (bus.rdata == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode for the frame sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    if (w_hs && (r_count == c_last)) w_next = DRAIN;
            DRAIN:   w_next = FLAG;
            FLAG:    w_next = POLL;
            POLL:    if (w_ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Registered RAM write stage, word counter and frame statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            bus.address <= '0;
            bus.wdata   <= '0;
            bus.enw     <= 1'b0;
            frame_done  <= 1'b0;
            frames      <= 16'd0;
        end else begin
            bus.enw    <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) r_count <= '0;
                end
                LOAD: begin
                    if (w_hs) begin
                        bus.enw     <= 1'b1;
                        bus.address <= c_base + WIDTH'(r_count);
                        bus.wdata   <= bus.in_data;
                        r_count     <= r_count + c_cnt_w'(1);
                    end
                end
                FLAG: begin
                    bus.enw     <= 1'b1;
                    bus.address <= c_ctrl;
                    bus.wdata   <= WIDTH'(1);
                end
                POLL: begin
                    if (w_ack) begin
                        frame_done <= 1'b1;
                        frames     <= frames + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
